instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 49 ++++
 rtl/instruction_fetch_unit_buffer.sv | 50 +++++
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFU_PREFETCH_BUF_EN selects a 2-entry prefetch FIFO instead of a single holding register.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } ifu_state_t;

    localparam logic [15:0] IFU_RESET_PC = 16'h0000;

    // Instruction word layout: [15:12] opcode, [11:9] rs1, [8:6] rs2, [5:0] offset
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS1_MSB = 11;
    localparam int RS1_LSB = 9;
    localparam int RS2_MSB = 8;
    localparam int RS2_LSB = 6;
    localparam int OFF_MSB = 5;
    localparam int OFF_LSB = 0;

    localparam logic [3:0] OPC_ALU    = 4'h0;
    localparam logic [3:0] OPC_LOAD   = 4'h1;
    localparam logic [3:0] OPC_STORE  = 4'h2;
    localparam logic [3:0] OPC_BRANCH = 4'h3;
    localparam logic [3:0] OPC_JUMP   = 4'h4;

`ifdef IFU_PREFETCH_BUF_EN
    localparam int IFU_BUF_DEPTH = 2;
`else
    localparam int IFU_BUF_DEPTH = 1;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ifu_entry_t;

    function automatic logic [15:0] branch_target(input logic [15:0] rpc, input logic [5:0] off);
        return rpc + 16'd1 + {{10{off[5]}}, off};
    endfunction

    function automatic logic [15:0] jump_target(input logic [15:0] rpc, input logic [11:0] fld);
        return {rpc[15:12], fld};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// Instruction buffer: holding register (depth 1) or FIFO (depth 2, IFU_PREFETCH_BUF_EN).
// Push lands next cycle; head is always entry 0; flush overrides push and pop.
module ifu_inst_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = IFU_BUF_DEPTH
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       push,
    input  ifu_entry_t push_entry,
    input  logic       pop,
    input  logic       flush,
    output ifu_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] wr_pos;
    ifu_entry_t    mem [DEPTH];

    // A simultaneous pop shifts the queue down, so the write slot moves with it.
    assign wr_pos = pop ? count - CW'(1) : count;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_pos) mem[i] <= push_entry;
                end
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect handling, buffer depth set by IFU_PREFETCH_BUF_EN.
// Request issues the cycle after the decision; decode backpressure via instrReady stops fetching when the buffer fills.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        fetchEnable,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemRdata,
    input  logic        imemAck,
    output logic        instrValid,
    output logic [15:0] instr,
    output logic [15:0] instrPc,
    input  logic        instrReady,
    input  logic        branchTaken,
    input  logic        jumpTaken,
    input  logic [15:0] redirectPc,
    input  logic [5:0]  offset,
    input  logic [11:0] offsetJump,
    output logic [15:0] pc
);

    ifu_state_t  state, state_n;
    logic [15:0] pc_n;
    logic        req_n;
    logic        new_req;
    logic        push, pop, flush;
    logic        redirect;
    logic [15:0] target;
    logic        buf_full, buf_empty, almost_full;
    ifu_entry_t  head;

    assign redirect = branchTaken | jumpTaken;
    assign target   = jumpTaken ? jump_target(redirectPc, offsetJump)
                                : branch_target(redirectPc, offset);
    assign pop      = instrValid & instrReady;

    // One free slot left: a push without a matching pop fills the buffer.
    assign almost_full = (IFU_BUF_DEPTH == 1) ? buf_empty : (!buf_empty && !buf_full);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imemReq;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            pc_n  = target;
            if (imemReq && !imemAck) begin
                state_n = DRAIN;
            end else begin
                req_n   = 1'b0;
                state_n = fetchEnable ? FETCH : IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (fetchEnable && !buf_full) state_n = FETCH;
                end
                FETCH: begin
                    if (imemReq) begin
                        if (imemAck) begin
                            push  = 1'b1;
                            pc_n  = pc + 16'd1;
                            req_n = 1'b0;
                            if (!pop && almost_full) state_n = FULL;
                            else if (!fetchEnable)   state_n = IDLE;
                            else                     req_n   = 1'b1;
                        end
                    end else if (!fetchEnable) begin
                        state_n = IDLE;
                    end else if (buf_full) begin
                        state_n = FULL;
                    end else begin
                        req_n = 1'b1;
                    end
                end
                DRAIN: begin
                    if (imemAck) begin
                        req_n   = 1'b0;
                        state_n = fetchEnable ? FETCH : IDLE;
                    end
                end
                FULL: begin
                    if (pop) state_n = FETCH;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // The address register only loads when a fresh request starts, so it holds through DRAIN.
    assign new_req = req_n && (!imemReq || imemAck);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            imemReq  <= 1'b0;
            imemAddr <= RESET_PC;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            imemReq <= req_n;
            if (new_req) imemAddr <= pc_n;
        end
    end

    ifu_inst_buffer #(.DEPTH(IFU_BUF_DEPTH)) u_buf (
        .clk        (clk),
        .resetN     (resetN),
        .push       (push),
        .push_entry ({imemRdata, imemAddr}),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign instrValid = !buf_empty;
    assign instr      = head.instr;
    assign instrPc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a memory responder and a transfer scoreboard.
module tb_instruction_fetch_unit;

`ifdef IFU_PREFETCH_BUF_EN
    localparam int EXP_FILL = 2;
`else
    localparam int EXP_FILL = 1;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        fetchEnable = 1'b0;
    logic        imemAck = 1'b0;
    logic [15:0] imemRdata = 16'h0;
    logic        instrReady = 1'b0;
    logic        branchTaken = 1'b0;
    logic        jumpTaken = 1'b0;
    logic [15:0] redirectPc = 16'h0;
    logic [5:0]  offset = 6'h0;
    logic [11:0] offsetJump = 12'h0;

    logic        imemReq, instrValid;
    logic [15:0] imemAddr, instr, instrPc, pc;
    logic        w_imemReq, w_instrValid;
    logic [15:0] w_imemAddr, w_instr, w_instrPc, w_pc;

    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    int          ack_cnt = 0;
    int          ack_base;
    logic [15:0] sb_q[$];

    instruction_fetch_unit dut (
        .clk(clk), .resetN(resetN), .fetchEnable(fetchEnable),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemRdata(imemRdata), .imemAck(imemAck),
        .instrValid(instrValid), .instr(instr), .instrPc(instrPc), .instrReady(instrReady),
        .branchTaken(branchTaken), .jumpTaken(jumpTaken), .redirectPc(redirectPc),
        .offset(offset), .offsetJump(offsetJump), .pc(pc)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .resetN(resetN), .fetchEnable(fetchEnable),
        .imemReq(w_imemReq), .imemAddr(w_imemAddr), .imemRdata(imemRdata), .imemAck(imemAck),
        .instrValid(w_instrValid), .instr(w_instr), .instrPc(w_instrPc), .instrReady(instrReady),
        .branchTaken(branchTaken), .jumpTaken(jumpTaken), .redirectPc(redirectPc),
        .offset(offset), .offsetJump(offsetJump), .pc(w_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return ({a[3:0], 12'h000} ^ (a * 16'd7)) ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input string tag, input int budget);
        bit done;
        done = (sb_q.size() == 0);
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (sb_q.size() == 0);
        end
        chk(tag, 16'(sb_q.size()), 16'h0);
    endtask

    // Memory: ack after mem_lat full request cycles, one-cycle pulse.
    initial begin : mem_model
        int   wc;
        logic was_ack;
        wc = 0;
        forever begin
            @(negedge clk);
            was_ack = imemAck;
            imemAck = 1'b0;
            if (resetN && imemReq) begin
                if (was_ack) wc = 0;
                if (wc >= mem_lat) begin
                    imemAck   = 1'b1;
                    imemRdata = mem_word(imemAddr);
                    ack_cnt++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Transfer monitor: every accepted instruction must match the scoreboard head.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (resetN && instrValid && instrReady) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_transfer", instrPc, 16'hxxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_pc", instrPc, e);
                    chk("xfer_instr", instr, mem_word(e));
                end
            end
        end
    end

    initial begin : main
        bit done, wdone;
        repeat (3) step();
        chk("rst_req", 16'(imemReq), 16'h0);
        chk("rst_valid", 16'(instrValid), 16'h0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_instrpc", instrPc, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_w_pc", w_pc, 16'hFFFF);
        chk("rst_w_valid", 16'(w_instrValid), 16'h0);
        chk("rst_w_instr", w_instr ^ w_instrPc, 16'h0000);

        // Straight-line fetch from reset
        for (int a = 0; a < 4; a++) sb_q.push_back(16'(a));
        instrReady  = 1'b1;
        fetchEnable = 1'b1;
        resetN      = 1'b1;
        step();
        chk("first_req_early", 16'(imemReq), 16'h0);
        step();
        chk("first_req", 16'(imemReq), 16'h1);
        chk("first_addr", imemAddr, 16'h0000);
        chk("w_first_addr", w_imemAddr, 16'hFFFF);
        done  = 1'b0;
        wdone = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            if (!wdone && w_imemReq && imemAddr == 16'h0001) begin
                chk("w_wrap_addr", w_imemAddr, 16'h0000);
                wdone = 1'b1;
            end
            done = (sb_q.size() == 0);
        end
        chk("seq_remaining", 16'(sb_q.size()), 16'h0);

        // Decode stalls: buffer fills, fetch stops
        instrReady = 1'b0;
        ack_base   = ack_cnt;
        repeat (10) step();
        chk("fill_acks", 16'(ack_cnt - ack_base), 16'(EXP_FILL));
        chk("fill_req", 16'(imemReq), 16'h0);
        chk("fill_valid", 16'(instrValid), 16'h1);
        chk("fill_head", instrPc, 16'h0004);

        // Taken branch with negative offset
        branchTaken = 1'b1;
        redirectPc  = 16'h0010;
        offset      = 6'h3E;
        step();
        branchTaken = 1'b0;
        chk("br_flush_valid", 16'(instrValid), 16'h0);
        chk("br_pc", pc, 16'h000F);
        step();
        chk("br_req", 16'(imemReq), 16'h1);
        chk("br_addr", imemAddr, 16'h000F);
        sb_q.push_back(16'h000F);
        sb_q.push_back(16'h0010);
        instrReady = 1'b1;
        wait_sb("br_seq_remaining", 80);
        instrReady = 1'b0;
        repeat (10) step();
        chk("br_head", instrPc, 16'h0011);

        // Jump and branch together; head accepted in the redirect cycle
        sb_q.push_back(16'h0011);
        instrReady  = 1'b1;
        jumpTaken   = 1'b1;
        branchTaken = 1'b1;
        redirectPc  = 16'hA005;
        offsetJump  = 12'h123;
        offset      = 6'h01;
        mem_lat     = 3;
        step();
        jumpTaken   = 1'b0;
        branchTaken = 1'b0;
        chk("jmp_valid", 16'(instrValid), 16'h0);
        chk("jmp_pc", pc, 16'hA123);
        chk("jmp_consumed", 16'(sb_q.size()), 16'h0);
        step();
        chk("jmp_req", 16'(imemReq), 16'h1);
        chk("jmp_addr", imemAddr, 16'hA123);

        // Two redirects while the A123 request waits for its ack
        step();
        branchTaken = 1'b1;
        redirectPc  = 16'h0100;
        offset      = 6'h05;
        step();
        branchTaken = 1'b0;
        chk("drain_pc", pc, 16'h0106);
        chk("drain_req_hold", 16'(imemReq), 16'h1);
        chk("drain_addr_hold", imemAddr, 16'hA123);
        jumpTaken  = 1'b1;
        redirectPc = 16'h2000;
        offsetJump = 12'h045;
        step();
        jumpTaken = 1'b0;
        chk("drain_pc2", pc, 16'h2045);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            chk("drain_valid", 16'(instrValid), 16'h0);
            done = imemReq && (imemAddr != 16'hA123);
        end
        chk("redir_req", 16'(imemReq), 16'h1);
        chk("redir_addr", imemAddr, 16'h2045);
        sb_q.push_back(16'h2045);
        wait_sb("redir_seq_remaining", 40);

        // Reset pulse while an instruction is buffered
        instrReady = 1'b0;
        for (int i = 0; i < 40 && !instrValid; i++) step();
        chk("pre_rst_valid", 16'(instrValid), 16'h1);
        resetN = 1'b0;
        #1;
        chk("rst2_req", 16'(imemReq), 16'h0);
        chk("rst2_valid", 16'(instrValid), 16'h0);
        chk("rst2_pc", pc, 16'h0000);
        chk("rst2_w_pc", w_pc, 16'hFFFF);
        repeat (3) step();
        chk("rst2_req_held", 16'(imemReq), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
